// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory responder: FSM encoding,
// RISC-V func3 access-size codes and small decode helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Width of the wait counter; WAIT_CYCLES must fit in it (0..15).
  localparam int WAIT_W = 4;

  // True for the five func3 codes the responder understands.
  function automatic logic size_legal(input logic [2:0] size);
    return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
           (size == SZ_BU) || (size == SZ_HU);
  endfunction

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if ((size == SZ_H) || (size == SZ_HU)) bad = addr_lo[0];
    if (size == SZ_W) bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational byte-lane datapath: byte enables and store merge for writes,
// lane select plus sign/zero extension for reads.
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [31:0] wrepl;
  logic [31:0] shifted;

  // Replicate right-aligned store data across all lanes and pick the enabled ones.
  always_comb begin
    byte_en = 4'b0000;
    wrepl   = wdata;
    case (size)
      SZ_B, SZ_BU: begin
        byte_en = 4'b0001 << addr_lo;
        wrepl   = {4{wdata[7:0]}};
      end
      SZ_H, SZ_HU: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wrepl   = {2{wdata[15:0]}};
      end
      SZ_W: begin
        byte_en = 4'b1111;
        wrepl   = wdata;
      end
      default: begin
        byte_en = 4'b0000;
        wrepl   = wdata;
      end
    endcase
    merged = rword;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged[i*8 +: 8] = wrepl[i*8 +: 8];
    end
  end

  // Shift the addressed lane down to bit 0 and extend it to 32 bits.
  always_comb begin
    shifted = rword >> {addr_lo, 3'b000};
    case (size)
      SZ_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      SZ_BU:   load_data = {24'd0, shifted[7:0]};
      SZ_HU:   load_data = {16'd0, shifted[15:0]};
      SZ_W:    load_data = shifted;
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/unified_mem_responder.sv
// Single-port memory responder: accepts one load/store at a time, waits a
// fixed number of cycles, then issues a one-cycle response strobe.
module unified_mem_responder
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_INIT = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        size_q, size_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              op_we;
  logic [31:0]       op_addr;
  logic [31:0]       op_wdata;
  logic [2:0]        op_size;
  logic              op_err;
  logic              enter_resp;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       rword;
  logic [3:0]        byte_en;
  logic [31:0]       merged;
  logic [31:0]       load_data;

  logic [31:0]       mem_q [DEPTH_WORDS];

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // With zero wait the response is formed on the accept edge itself, so the
  // operands come straight from the request port while idle.
  always_comb begin
    op_we    = we_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_size  = size_q;
    if (state_q == ST_IDLE) begin
      op_we    = req_we;
      op_addr  = req_addr;
      op_wdata = req_wdata;
      op_size  = req_size;
    end
    op_err  = !size_legal(op_size) || misaligned(op_size, op_addr[1:0]) ||
              ({2'b00, op_addr[31:2]} >= DEPTH_L);
    mem_idx = op_addr[IDX_W+1:2];
    rword   = mem_q[mem_idx];
  end

  byte_lane_unit u_lanes (
    .size      (op_size),
    .addr_lo   (op_addr[1:0]),
    .wdata     (op_wdata),
    .rword     (rword),
    .byte_en   (byte_en),
    .merged    (merged),
    .load_data (load_data)
  );

  // Next-state, request latching and response formation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    enter_resp  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = op_err;
      rsp_rdata_d = (!op_we && !op_err) ? load_data : 32'd0;
    end
    mem_we = enter_resp && op_we && !op_err && (byte_en != 4'b0000) && rst;
  end

  // Control and response registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      size_q      <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= merged;
  end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench: a vector table against the default-latency instance, plus
// sequences for zero-wait streaming and reset in the middle of a store.
module tb_unified_mem_responder;
  import mem_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        vld2, rdy2, rv2, re2;
  logic [31:0] rd2;
  logic        vld0, rdy0, rv0, re0;
  logic [31:0] rd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unified_mem_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .req_valid(vld2), .req_ready(rdy2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2));

  unified_mem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .req_valid(vld0), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0));

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Issue one request to the chosen instance; lat counts cycles after the
  // accept edge, the cycle right after it being 1. Called just after a posedge.
  task automatic apply_stimulus(input bit use0, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] size,
                                output logic [31:0] rdata, output logic err, output int lat);
    bit accepted;
    logic rdy;
    accepted  = 1'b0;
    lat       = 0;
    rdata     = 32'd0;
    err       = 1'b0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    if (use0) vld0 = 1'b1; else vld2 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rdy = use0 ? rdy0 : rdy2;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    vld0 = 1'b0;
    vld2 = 1'b0;
    if (!accepted) begin
      report_timeout("accept");
      return;
    end
    for (int i = 1; i <= 40; i++) begin
      if (use0 ? rv0 : rv2) begin
        lat   = i;
        rdata = use0 ? rd0 : rd2;
        err   = use0 ? re0 : re2;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat == 0) report_timeout("response");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc[$];
    int          nrsp;
    int          seen;
    logic        rdy;

    rst = 1'b0; vld2 = 1'b0; vld0 = 1'b0;
    req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_size = SZ_W;

    // Outputs while reset is held.
    #1;
    check_output("rst_rsp_valid", {31'd0, rv2}, 32'd0);
    check_output("rst_rsp_rdata", rd2, 32'd0);
    check_output("rst_rsp_err", {31'd0, re2}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_output("ready_after_rst", {31'd0, rdy2}, 32'd1);
    check_output("ready0_after_rst", {31'd0, rdy0}, 32'd1);
    @(posedge clk);
    #1;

    vecs.push_back('{"st_w10",    1'b1, 32'h10,       32'hDEADBEEF, SZ_W,   32'h0,        1'b0});
    vecs.push_back('{"ld_w10",    1'b0, 32'h10,       32'h0,        SZ_W,   32'hDEADBEEF, 1'b0});
    vecs.push_back('{"ld_b13",    1'b0, 32'h13,       32'h0,        SZ_B,   32'hFFFFFFDE, 1'b0});
    vecs.push_back('{"ld_bu13",   1'b0, 32'h13,       32'h0,        SZ_BU,  32'h000000DE, 1'b0});
    vecs.push_back('{"ld_hu12",   1'b0, 32'h12,       32'h0,        SZ_HU,  32'h0000DEAD, 1'b0});
    vecs.push_back('{"ld_h12",    1'b0, 32'h12,       32'h0,        SZ_H,   32'hFFFFDEAD, 1'b0});
    vecs.push_back('{"st_b11",    1'b1, 32'h11,       32'h000000AA, SZ_B,   32'h0,        1'b0});
    vecs.push_back('{"ld_merge",  1'b0, 32'h10,       32'h0,        SZ_W,   32'hDEADAAEF, 1'b0});
    vecs.push_back('{"ld_h10",    1'b0, 32'h10,       32'h0,        SZ_H,   32'hFFFFAAEF, 1'b0});
    vecs.push_back('{"st_misal",  1'b1, 32'h12,       32'h11111111, SZ_W,   32'h0,        1'b1});
    vecs.push_back('{"ld_unchg",  1'b0, 32'h10,       32'h0,        SZ_W,   32'hDEADAAEF, 1'b0});
    vecs.push_back('{"ld_oor",    1'b0, 32'(4*DEPTH), 32'h0,        SZ_W,   32'h0,        1'b1});
    vecs.push_back('{"ld_badsz",  1'b0, 32'h10,       32'h0,        3'b011, 32'h0,        1'b1});
    vecs.push_back('{"ld_misal_h",1'b0, 32'h11,       32'h0,        SZ_H,   32'h0,        1'b1});
    vecs.push_back('{"ld_nowrap", 1'b0, 32'hFFFFFFF0, 32'h0,        SZ_W,   32'h0,        1'b1});
    vecs.push_back('{"st_last",   1'b1, 32'(4*DEPTH-4), 32'h0BADCAFE, SZ_W, 32'h0,        1'b0});
    vecs.push_back('{"ld_last",   1'b0, 32'(4*DEPTH-4), 32'h0,      SZ_W,   32'h0BADCAFE, 1'b0});
    vecs.push_back('{"st_w14",    1'b1, 32'h14,       32'h00000000, SZ_W,   32'h0,        1'b0});
    vecs.push_back('{"st_h16",    1'b1, 32'h16,       32'h5678ABCD, SZ_H,   32'h0,        1'b0});
    vecs.push_back('{"ld_w14",    1'b0, 32'h14,       32'h0,        SZ_W,   32'hABCD0000, 1'b0});
    vecs.push_back('{"ld_b17",    1'b0, 32'h17,       32'h0,        SZ_B,   32'hFFFFFFAB, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, rdata, err, lat);
      check_output({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
      check_output({vecs[i].name, "_err"}, {31'd0, err}, {31'd0, vecs[i].exp_err});
      check_output({vecs[i].name, "_lat"}, 32'(lat), 32'd3);
    end

    // Zero-wait instance: single store/load latency.
    apply_stimulus(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, SZ_W, rdata, err, lat);
    check_output("w0_st_lat", 32'(lat), 32'd1);
    check_output("w0_st_err", {31'd0, err}, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, SZ_W, rdata, err, lat);
    check_output("w0_ld_lat", 32'(lat), 32'd1);
    check_output("w0_ld_rdata", rdata, 32'hCAFEF00D);

    // Zero-wait instance with valid held high: accepts every other cycle.
    req_we = 1'b0; req_addr = 32'h10; req_size = SZ_W;
    vld0 = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 12; c++) begin
      rdy = rdy0;
      @(posedge clk);
      #1;
      if (rdy) acc.push_back(c);
      if (rv0) nrsp++;
    end
    vld0 = 1'b0;
    check_output("w0_stream_accepts", 32'(acc.size()), 32'd6);
    check_output("w0_stream_rsps", 32'(nrsp), 32'd6);
    for (int i = 1; i < acc.size(); i++)
      check_output("w0_stream_spacing", 32'(acc[i] - acc[i-1]), 32'd2);
    @(posedge clk);
    #1;

    // Reset while a store sits in WAIT: it must vanish without a response.
    apply_stimulus(1'b0, 1'b1, 32'h20, 32'h11112222, SZ_W, rdata, err, lat);
    check_output("pre_st_err", {31'd0, err}, 32'd0);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = SZ_W;
    vld2 = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      rdy = rdy2;
      @(posedge clk);
      #1;
      if (rdy) seen = 1;
    end
    vld2 = 1'b0;
    if (seen == 0) report_timeout("rst_accept");
    @(posedge clk);
    #1;
    check_output("wait_ready_low", {31'd0, rdy2}, 32'd0);
    rst = 1'b0;
    #1;
    check_output("midrst_ready", {31'd0, rdy2}, 32'd1);
    check_output("midrst_valid", {31'd0, rv2}, 32'd0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (rv2) seen++;
    end
    rst = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (rv2) seen++;
    end
    check_output("midrst_no_rsp", 32'(seen), 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'h20, 32'h0, SZ_W, rdata, err, lat);
    check_output("midrst_mem_kept", rdata, 32'h11112222);
    check_output("midrst_ld_err", {31'd0, err}, 32'd0);

    @(posedge clk);
    #1;
    check_output("idle_rdata_zero", rd2, 32'd0);
    check_output("idle_err_zero", {31'd0, re2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
